// File: rtl/port_uart_tx_pkg.sv
// Shared definitions for the port-driven UART transmitter: FSM state
// encodings, status/control bit positions and a status-byte packer.
package port_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bit positions inside port_status
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Bit positions inside port_ctrl
  localparam int CTRL_TOG = 0;
  localparam int CTRL_CLR = 1;

  // Assemble the status byte; unused upper bits read as zero
  function automatic logic [7:0] pack_status(input logic ovf, input logic busy,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_OVF]   = ovf;
    s[STAT_BUSY]  = busy;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    return s;
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Small synchronous FIFO with show-ahead read data. A push while full is
// accepted only when a pop happens on the same edge, so the count holds.
module port_fifo
  import port_uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Gate requests against occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en)      count_d = count_q + (AW+1)'(1);
    else if (!wr_en && rd_en) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/port_uart_tx.sv
// UART 8N1 transmitter fed from two computer output ports. Software writes
// a byte by toggling the control toggle bit; bytes queue in a FIFO and are
// sent LSB first. A status byte reports overflow/busy/empty/full.
module port_uart_tx
  import port_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_data,
  input  logic [7:0] port_ctrl,
  output logic [7:0] port_status,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           prev_tog_q, prev_tog_d;
  logic           ovf_q, ovf_d;

  logic           push_evt, pop, baud_done;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic           unused_ctrl_bits;

  assign unused_ctrl_bits = ^port_ctrl[7:2];

  port_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push_evt),
    .pop     (pop),
    .wr_data (port_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  // Write detection and sticky overflow; a drop wins over a clear
  always_comb begin
    prev_tog_d = port_ctrl[CTRL_TOG];
    push_evt   = port_ctrl[CTRL_TOG] ^ prev_tog_q;
    ovf_d      = ovf_q;
    if (port_ctrl[CTRL_CLR])            ovf_d = 1'b0;
    if (push_evt && fifo_full && !pop)  ovf_d = 1'b1;
  end

  // State register plus datapath registers of the serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      prev_tog_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      prev_tog_q <= prev_tog_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state logic: baud/bit counting, shifting and FIFO pops
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next frame when more bytes are queued
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: line level follows the state being entered so tx is registered
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign port_status = pack_status(ovf_q, state_q != ST_IDLE, fifo_empty, fifo_full);

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx: stimulus pushes expected bytes into a
// scoreboard queue; a line monitor decodes frames from tx and compares.
module tb_port_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] port_data;
  logic [7:0] port_ctrl;
  logic [7:0] port_status;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];

  bit         mon_active = 0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;

  port_uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_data   (port_data),
    .port_ctrl   (port_ctrl),
    .port_status (port_status),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Issue one write: new data plus a toggle; optionally expect it on the line
  task automatic push_byte(input logic [7:0] b, input bit expect_sent);
    port_data    = b;
    port_ctrl[0] = ~port_ctrl[0];
    if (expect_sent) exp_q.push_back(b);
    tick();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (frames < target) begin
      errors++;
      $display("FAIL wait_frames: got %0d frames expected %0d", frames, target);
    end
  endtask

  // Line monitor: frame start at first low sample, bits sampled mid-cell
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        starts_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL start_bit: got %b expected 0", tx);
        end
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
        mon_byte = {tx, mon_byte[7:1]};
      end else if (mon_cnt == 38) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit: got %b expected 1", tx);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got unexpected byte %h expected none", mon_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (mon_byte !== e) begin
            errors++;
            $display("FAIL frame: got %h expected %h", mon_byte, e);
          end else begin
            $display("ok   frame: %h", mon_byte);
          end
        end
        frames++;
        mon_active = 0;
      end
    end
  end

  initial begin
    int f0;
    int s0;

    reset     = 1'b0;
    port_data = 8'h00;
    port_ctrl = 8'h00;

    // Reset state
    idle(2);
    check8("reset_tx", {7'b0, tx}, 8'h01);
    check8("reset_status", port_status, 8'h02);
    reset = 1'b1;
    idle(50);
    check8("idle_status", port_status, 8'h02);
    check_int("idle_no_frames", starts_q.size(), 0);

    // Single byte 0x55: latency and status during the frame
    push_byte(8'h55, 1'b1);
    check8("lat_k_tx", {7'b0, tx}, 8'h01);
    check8("lat_k_status", port_status, 8'h00);
    tick();
    check8("lat_k1_tx", {7'b0, tx}, 8'h00);
    check8("lat_k1_status", port_status, 8'h06);
    wait_frames(1, 60);
    idle(5);
    check8("post55_status", port_status, 8'h02);

    // Four back-to-back bytes: no idle gap between frames
    f0 = frames;
    s0 = starts_q.size();
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hA3, 1'b1);
    push_byte(8'hA4, 1'b1);
    wait_frames(f0 + 4, 220);
    for (int i = 0; i < 3; i++)
      check_int("frame_gap", starts_q[s0 + i + 1] - starts_q[s0 + i], 40);
    idle(5);
    check8("postA_status", port_status, 8'h02);

    // Six bytes into a four-deep FIFO: last one dropped, overflow sticky
    f0 = frames;
    for (int i = 0; i < 6; i++)
      push_byte(8'h10 + 8'(i), i < 5);
    check8("ovf_status", port_status, 8'h0D);
    port_ctrl[1] = 1'b1;
    tick();
    port_ctrl[1] = 1'b0;
    check8("ovf_clear_status", port_status, 8'h05);
    wait_frames(f0 + 5, 260);
    idle(60);
    check_int("ovf_frame_count", frames, f0 + 5);

    // Push coinciding with a STOP-state pop while full
    f0 = frames;
    for (int i = 0; i < 5; i++)
      push_byte(8'hC0 + 8'(i), 1'b1);
    idle(36);
    check8("pre_coincide_status", port_status, 8'h05);
    push_byte(8'hC5, 1'b1);
    check8("coincide_status", port_status, 8'h05);
    wait_frames(f0 + 6, 300);
    idle(50);
    check8("post_coincide_status", port_status, 8'h02);

    // Reset mid-frame: line returns high at once, queued data lost
    f0 = frames;
    push_byte(8'hFF, 1'b1);
    idle(10);
    reset        = 1'b0;
    port_ctrl[0] = 1'b0;
    #1;
    check8("midreset_tx", {7'b0, tx}, 8'h01);
    exp_q.delete();
    idle(2);
    check8("midreset_status", port_status, 8'h02);
    reset = 1'b1;
    idle(1);
    check8("post_reset_status", port_status, 8'h02);
    idle(60);
    check_int("post_reset_frames", frames, f0);
    check8("post_reset_tx", {7'b0, tx}, 8'h01);

    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
